// File: rtl/seq_multiplier_taint.sv
// Sequential shift-add multiplier with per-bit taint tracking, BITS_PER_CYCLE multiplier bits per cycle.
// Optional build macro MULT_EARLY_TERM_EN ends CALC once the remaining multiplier bits are all zero.
module seq_multiplier_taint #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               start_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplier_t,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplicand_t,
  input  logic               signed_mode,
  input  logic               signed_mode_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t,
  output logic               productDone,
  output logic               productDone_t,
  output logic               busy,
  output logic               busy_t
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int B  = BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Taint of a carry chain: every bit at or above any tainted bit is tainted.
  function automatic logic [SW-1:0] smear_up(input logic [SW-1:0] x);
    logic [SW-1:0] r;
    r = x;
    for (int i = 1; i < SW; i++) r[i] = r[i] | r[i-1];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] smear_w(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    for (int i = 1; i < WIDTH; i++) r[i] = r[i] | r[i-1];
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d, mplier_t_q, mplier_t_d;
  logic [SW-1:0]     mcand_q, mcand_d, mcand_t_q, mcand_t_d;
  logic [SW-1:0]     mask_q, mask_d, sum_q, sum_d, sum_t_q, sum_t_d;
  logic              neg_q, neg_d, all_t_q, all_t_d, ctrl_q, ctrl_d, et_q, et_d;
  logic [PW-1:0]     product_q, product_d, product_t_q, product_t_d;
  logic              done_q, done_d, done_t_q, done_t_d, busy_q, busy_d, busy_t_q, busy_t_d;

  logic [B-1:0]      chunk_s, chunk_t_s;
  logic [SW-1:0]     pp_s, pp_t_s, acc_s, acc_t_s;
  logic [WIDTH-1:0]  rem_s;
  logic              last_s, a_neg_s, b_neg_s, et_load_s;
  logic [PW-1:0]     res_s;

  assign chunk_s   = mplier_q[B-1:0];
  assign chunk_t_s = mplier_t_q[B-1:0];
  assign pp_s      = mcand_q * {{(SW-B){1'b0}}, chunk_s};
  assign acc_s     = sum_q + pp_s;
  assign acc_t_s   = smear_up(sum_t_q | pp_t_s);
  assign rem_s     = mplier_q >> B;
  assign res_s     = neg_q ? (~acc_s[PW-1:0] + PW'(1)) : acc_s[PW-1:0];
  assign a_neg_s   = signed_mode & multiplier[WIDTH-1];
  assign b_neg_s   = signed_mode & multiplicand[WIDTH-1];

`ifdef MULT_EARLY_TERM_EN
  assign last_s    = (cnt_q == CW'(N-1)) || (rem_s == {WIDTH{1'b0}});
  assign et_load_s = |multiplier_t;
`else
  assign last_s    = (cnt_q == CW'(N-1));
  assign et_load_s = 1'b0;
`endif

  // Partial-product taint: tainted chunk poisons everything from its offset upward.
  always_comb begin
    pp_t_s = {SW{1'b0}};
    if (|chunk_t_s) begin
      pp_t_s = mask_q;
    end else if (|chunk_s) begin
      pp_t_s = smear_up(mcand_t_q);
    end else begin
      pp_t_s = {SW{1'b0}};
    end
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mplier_d    = mplier_q;
    mplier_t_d  = mplier_t_q;
    mcand_d     = mcand_q;
    mcand_t_d   = mcand_t_q;
    mask_d      = mask_q;
    sum_d       = sum_q;
    sum_t_d     = sum_t_q;
    neg_d       = neg_q;
    all_t_d     = all_t_q;
    ctrl_d      = ctrl_q;
    et_d        = et_q;
    product_d   = product_q;
    product_t_d = product_t_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mplier_d   = a_neg_s ? (~multiplier + WIDTH'(1)) : multiplier;
          mplier_t_d = a_neg_s ? smear_w(multiplier_t) : multiplier_t;
          mcand_d    = {{(SW-WIDTH){1'b0}}, (b_neg_s ? (~multiplicand + WIDTH'(1)) : multiplicand)};
          mcand_t_d  = {{(SW-WIDTH){1'b0}}, (b_neg_s ? smear_w(multiplicand_t) : multiplicand_t)};
          mask_d     = {SW{1'b1}};
          sum_d      = {SW{1'b0}};
          sum_t_d    = {SW{1'b0}};
          cnt_d      = {CW{1'b0}};
          neg_d      = a_neg_s ^ b_neg_s;
          // A tainted sign decision can flip the whole result.
          all_t_d    = (signed_mode_t & (multiplier[WIDTH-1] | multiplicand[WIDTH-1])) |
                       (signed_mode & (multiplier_t[WIDTH-1] | multiplicand_t[WIDTH-1]));
          ctrl_d     = start_t;
          et_d       = et_load_s;
          state_d    = CALC;
        end else begin
          state_d    = IDLE;
        end
      end
      CALC: begin
        sum_d      = acc_s;
        sum_t_d    = acc_t_s;
        mplier_d   = mplier_q >> B;
        mplier_t_d = mplier_t_q >> B;
        mcand_d    = mcand_q << B;
        mcand_t_d  = mcand_t_q << B;
        mask_d     = mask_q << B;
        cnt_d      = cnt_q + CW'(1);
        if (last_s) begin
          product_d   = res_s;
          product_t_d = (ctrl_q | all_t_q) ? {PW{1'b1}} : acc_t_s[PW-1:0];
          state_d     = DONE;
        end else begin
          state_d     = CALC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d   = (state_d == CALC);
    done_d   = (state_d == DONE);
    busy_t_d = ctrl_d | et_d;
    done_t_d = ctrl_d | et_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      mplier_t_q  <= {WIDTH{1'b0}};
      mcand_q     <= {SW{1'b0}};
      mcand_t_q   <= {SW{1'b0}};
      mask_q      <= {SW{1'b0}};
      sum_q       <= {SW{1'b0}};
      sum_t_q     <= {SW{1'b0}};
      neg_q       <= 1'b0;
      all_t_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      et_q        <= 1'b0;
      product_q   <= {PW{1'b0}};
      product_t_q <= {PW{1'b0}};
      done_q      <= 1'b0;
      done_t_q    <= 1'b0;
      busy_q      <= 1'b0;
      busy_t_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mplier_q    <= mplier_d;
      mplier_t_q  <= mplier_t_d;
      mcand_q     <= mcand_d;
      mcand_t_q   <= mcand_t_d;
      mask_q      <= mask_d;
      sum_q       <= sum_d;
      sum_t_q     <= sum_t_d;
      neg_q       <= neg_d;
      all_t_q     <= all_t_d;
      ctrl_q      <= ctrl_d;
      et_q        <= et_d;
      product_q   <= product_d;
      product_t_q <= product_t_d;
      done_q      <= done_d;
      done_t_q    <= done_t_d;
      busy_q      <= busy_d;
      busy_t_q    <= busy_t_d;
    end
  end

  // While the control-taint flag is set every product bit reads as tainted.
  assign product       = product_q;
  assign product_t     = product_t_q | {PW{ctrl_q}};
  assign productDone   = done_q;
  assign productDone_t = done_t_q;
  assign busy          = busy_q;
  assign busy_t        = busy_t_q;

endmodule

// File: tb/tb_seq_multiplier_taint.sv
// Directed bench for seq_multiplier_taint at WIDTH=8, BITS_PER_CYCLE=2.
module tb_seq_multiplier_taint;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start_t = 1'b0;
  logic [7:0]  multiplier = 8'd0, multiplier_t = 8'd0;
  logic [7:0]  multiplicand = 8'd0, multiplicand_t = 8'd0;
  logic        signed_mode = 1'b0, signed_mode_t = 1'b0;
  logic [15:0] product, product_t;
  logic        productDone, productDone_t, busy, busy_t;

  int tests_run = 0;
  int tests_failed = 0;

  seq_multiplier_taint #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst),
    .start(start), .start_t(start_t),
    .multiplier(multiplier), .multiplier_t(multiplier_t),
    .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
    .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
    .product(product), .product_t(product_t),
    .productDone(productDone), .productDone_t(productDone_t),
    .busy(busy), .busy_t(busy_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the accept edge (counted as 1) until productDone is seen.
  function automatic int exp_cycles(input logic [7:0] mr, input logic sg);
    logic [7:0] mag;
    int k;
    mag = (sg && mr[7]) ? (~mr + 8'd1) : mr;
    k = 1;
    for (int i = 1; i < 4; i++) if ((mag >> (2 * i)) != 8'd0) k = i + 1;
    return (EARLY ? k : 4) + 1;
  endfunction

  task automatic run_op(input string tag, input logic [7:0] mr, input logic [7:0] mr_t,
                        input logic [7:0] md, input logic [7:0] md_t,
                        input logic sg, input logic sg_t, input logic st_t, input logic poke,
                        input logic [15:0] exp_p, input logic [15:0] exp_pt);
    int cyc;
    int exp_c;
    logic exp_tt;
    exp_c  = exp_cycles(mr, sg);
    exp_tt = st_t | (EARLY & (|mr_t));
    @(negedge clk);
    multiplier = mr; multiplier_t = mr_t; multiplicand = md; multiplicand_t = md_t;
    signed_mode = sg; signed_mode_t = sg_t; start_t = st_t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, 64'(busy), 64'(1'b1));
    check({tag, "_busy_t"}, 64'(busy_t), 64'(exp_tt));
    while (productDone !== 1'b1 && cyc < 20) begin
      if (poke && cyc == 1) begin
        start = 1'b1; multiplier = 8'hAA; multiplicand = 8'h55;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_c));
    check({tag, "_product"}, 64'(product), 64'(exp_p));
    check({tag, "_product_t"}, 64'(product_t), 64'(exp_pt));
    check({tag, "_done_t"}, 64'(productDone_t), 64'(exp_tt));
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 64'(productDone), 64'(1'b0));
    check({tag, "_hold"}, 64'(product), 64'(exp_p));
  endtask

  initial begin : main
    logic seen;
    #12;
    check("rst_product", 64'(product), 64'd0);
    check("rst_product_t", 64'(product_t), 64'd0);
    check("rst_done", 64'(productDone), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_taints", 64'({busy_t, productDone_t}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("u13x11",  8'd13,  8'h00, 8'd11,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd143,  16'h0000);
    run_op("sneg3x5", 8'hFD,  8'h00, 8'h05,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFF1, 16'h0000);
    run_op("mdtaint", 8'h01,  8'h00, 8'h25,  8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0025, 16'hFF80);
    run_op("ctrl_t",  8'd7,   8'h00, 8'd9,   8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd63,   16'hFFFF);
    run_op("ctrl_clr",8'd2,   8'h00, 8'd3,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd6,    16'h0000);
    run_op("smin",    8'h80,  8'h00, 8'h80,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000);
    run_op("sgn_t",   8'h80,  8'h00, 8'h02,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hFFFF);
    run_op("umax",    8'hFF,  8'h00, 8'hFF,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFE01, 16'h0000);
    run_op("ignore",  8'h0F,  8'h00, 8'h0F,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00E1, 16'h0000);
    run_op("mr_t",    8'h03,  8'h01, 8'h10,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, 16'hFFFF);

    // Reset during the second CALC cycle.
    @(negedge clk);
    multiplier = 8'h55; multiplier_t = 8'h00; multiplicand = 8'h33; multiplicand_t = 8'h00;
    signed_mode = 1'b0; signed_mode_t = 1'b0; start_t = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(productDone), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | productDone;
    end
    check("midrst_nopulse", 64'(seen), 64'd0);
    run_op("after_rst", 8'd6, 8'h00, 8'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd42, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
